br_resolve_unit: RTL and testbench

BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

---
 rtl/br_resolve_unit_pkg.sv | 31 +++
 rtl/br_resolve_unit_fifo.sv | 61 ++++++
 rtl/br_resolve_unit.sv | 104 ++++++++++
 tb/tb_br_resolve_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: branch kinds, FIFO states and the
// resolved-branch payload carried from the branch unit to the CDB.
package params;

  localparam int unsigned ROB_IDX_W_DEF = 5;
  localparam int unsigned PREG_W_DEF    = 6;

  typedef enum logic [1:0] {
    BR_KIND_BR   = 2'd0,
    BR_KIND_JAL  = 2'd1,
    BR_KIND_JALR = 2'd2
  } br_kind_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_t;

  typedef struct packed {
    logic        rd_we;
    logic        mispredict;
    logic [31:0] data;
    logic [31:0] target;
  } br_res_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_resolve_unit_fifo.sv
// Two-entry skid FIFO holding resolved branch results; the head is read
// straight from storage registers so nothing from the push side reaches pop_*.
module br_res_fifo
  import params::*;
#(
  parameter type T = br_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);

  fifo_state_t state;
  logic        wr_ptr;
  logic        rd_ptr;
  T            mem [2];
  logic        push;
  logic        pop;

  assign push_ready = (state != FIFO_TWO);
  assign pop_valid  = (state != FIFO_EMPTY);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      state  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case (state)
        FIFO_EMPTY: if (push) state <= FIFO_ONE;
        FIFO_ONE: begin
          if (push && !pop)      state <= FIFO_TWO;
          else if (pop && !push) state <= FIFO_EMPTY;
        end
        FIFO_TWO: if (pop) state <= FIFO_ONE;
        default:  state <= FIFO_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: computes taken/target/link/mispredict at push time and
// queues results for the CDB. Optional counters under BR_RESOLVE_PERF_EN.
module br_resolve_unit
  import params::*;
#(
  parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int unsigned PREG_W    = PREG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PREG_W-1:0]    in_pd,
  input  logic                 in_rd_we,
  input  br_kind_t             in_kind,
  input  logic [31:0]          in_pc,
  input  logic                 in_cmp,
  input  logic [31:0]          in_add,
  input  logic                 in_pred_taken,
  input  logic [31:0]          in_pred_target,
  input  logic                 flush,
  output logic                 cdb_valid,
  input  logic                 cdb_ready,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_pd,
  output logic                 cdb_rd_we,
  output logic [31:0]          cdb_data,
  output logic                 cdb_mispredict,
  output logic [31:0]          cdb_target
`ifdef BR_RESOLVE_PERF_EN
  ,
  output logic [31:0]          perf_resolved,
  output logic [31:0]          perf_mispredict
`endif
);

  // Tags are sized by this instance's parameters, so wrap the shared payload.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pd;
    br_res_t              res;
  } entry_t;

  entry_t      push_entry;
  entry_t      head;
  logic        actual_taken;
  logic [31:0] seq_pc;

  always_comb begin
    seq_pc       = next_seq_pc(in_pc);
    actual_taken = (in_kind == BR_KIND_BR) ? in_cmp : 1'b1;

    push_entry                = '0;
    push_entry.rob_idx        = in_rob_idx;
    push_entry.pd             = in_pd;
    push_entry.res.target     = actual_taken ? in_add : seq_pc;
    push_entry.res.mispredict = (actual_taken != in_pred_taken) ||
                                (actual_taken && (in_add != in_pred_target));
    if (in_kind != BR_KIND_BR) begin
      push_entry.res.data  = seq_pc;
      push_entry.res.rd_we = in_rd_we;
    end
  end

  br_res_fifo #(
    .T (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_entry),
    .pop_valid  (cdb_valid),
    .pop_ready  (cdb_ready),
    .pop_data   (head)
  );

  assign cdb_rob_idx    = head.rob_idx;
  assign cdb_pd         = head.pd;
  assign cdb_rd_we      = head.res.rd_we;
  assign cdb_data       = head.res.data;
  assign cdb_mispredict = head.res.mispredict;
  assign cdb_target     = head.res.target;

`ifdef BR_RESOLVE_PERF_EN
  // A pop coinciding with flush is not a broadcast, so it is not counted.
  logic pop_fire;
  assign pop_fire = cdb_valid && cdb_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_resolved   <= '0;
      perf_mispredict <= '0;
    end else if (pop_fire) begin
      if (perf_resolved != '1) perf_resolved <= perf_resolved + 32'd1;
      if (head.res.mispredict && (perf_mispredict != '1))
        perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: expected results queued at push,
// compared at each CDB handshake; directed cases plus a random run.
module tb_br_resolve_unit;
  import params::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rob_idx;
  logic [5:0]  in_pd;
  logic        in_rd_we;
  br_kind_t    in_kind;
  logic [31:0] in_pc;
  logic        in_cmp;
  logic [31:0] in_add;
  logic        in_pred_taken;
  logic [31:0] in_pred_target;
  logic        flush;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_idx;
  logic [5:0]  cdb_pd;
  logic        cdb_rd_we;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
`ifdef BR_RESOLVE_PERF_EN
  logic [31:0] perf_resolved;
  logic [31:0] perf_mispredict;
  int unsigned exp_resolved;
  int unsigned exp_mispredict;
`endif

  br_resolve_unit #(
    .ROB_IDX_W (5),
    .PREG_W    (6)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rob_idx     (in_rob_idx),
    .in_pd          (in_pd),
    .in_rd_we       (in_rd_we),
    .in_kind        (in_kind),
    .in_pc          (in_pc),
    .in_cmp         (in_cmp),
    .in_add         (in_add),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .flush          (flush),
    .cdb_valid      (cdb_valid),
    .cdb_ready      (cdb_ready),
    .cdb_rob_idx    (cdb_rob_idx),
    .cdb_pd         (cdb_pd),
    .cdb_rd_we      (cdb_rd_we),
    .cdb_data       (cdb_data),
    .cdb_mispredict (cdb_mispredict),
    .cdb_target     (cdb_target)
`ifdef BR_RESOLVE_PERF_EN
    ,
    .perf_resolved   (perf_resolved),
    .perf_mispredict (perf_mispredict)
`endif
  );

  typedef struct packed {
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic        rd_we;
    logic        mis;
    logic [31:0] data;
    logic [31:0] target;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        prev_stall = 1'b0;
  logic [76:0] prev_word;
  logic        rand_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input br_kind_t k, input logic [31:0] pc, input logic cmp,
                                 input logic [31:0] add, input logic pt, input logic [31:0] ptg,
                                 input logic [4:0] rob, input logic [5:0] pd, input logic we);
    exp_t        e;
    logic        taken;
    logic [31:0] link;
    link     = pc + 32'd4;
    taken    = (k == BR_KIND_BR) ? cmp : 1'b1;
    e.rob    = rob;
    e.pd     = pd;
    e.target = taken ? add : link;
    e.mis    = (taken != pt) || (taken && (add != ptg));
    e.data   = (k == BR_KIND_BR) ? 32'd0 : link;
    e.rd_we  = (k == BR_KIND_BR) ? 1'b0 : we;
    return e;
  endfunction

  // Monitor: inputs are settled at the falling edge for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
`ifdef BR_RESOLVE_PERF_EN
      exp_resolved   = 0;
      exp_mispredict = 0;
`endif
    end else begin
      if (cdb_valid && prev_stall)
        check("cdb_stable",
              {cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_mispredict, cdb_target, cdb_data}, prev_word);
      if (cdb_valid && cdb_ready && !flush) begin
        if (sb.size() == 0) begin
          check("unexpected_cdb", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("cdb_rob_idx", cdb_rob_idx, mon_e.rob);
          check("cdb_pd", cdb_pd, mon_e.pd);
          check("cdb_rd_we", cdb_rd_we, mon_e.rd_we);
          check("cdb_data", cdb_data, mon_e.data);
          check("cdb_target", cdb_target, mon_e.target);
          check("cdb_mispredict", cdb_mispredict, mon_e.mis);
`ifdef BR_RESOLVE_PERF_EN
          exp_resolved++;
          if (mon_e.mis) exp_mispredict++;
`endif
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(model(in_kind, in_pc, in_cmp, in_add, in_pred_taken, in_pred_target,
                           in_rob_idx, in_pd, in_rd_we));
      prev_stall = cdb_valid && !cdb_ready && !flush;
      prev_word  = {cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_mispredict, cdb_target, cdb_data};
    end
  end

  task automatic set_in(input br_kind_t k, input logic [31:0] pc, input logic cmp,
                        input logic [31:0] add, input logic pt, input logic [31:0] ptg,
                        input logic [4:0] rob, input logic [5:0] pd, input logic we);
    in_kind        = k;
    in_pc          = pc;
    in_cmp         = cmp;
    in_add         = add;
    in_pred_taken  = pt;
    in_pred_target = ptg;
    in_rob_idx     = rob;
    in_pd          = pd;
    in_rd_we       = we;
    in_valid       = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check(tag, 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push(input br_kind_t k, input logic [31:0] pc, input logic cmp,
                      input logic [31:0] add, input logic pt, input logic [31:0] ptg,
                      input logic [4:0] rob, input logic [5:0] pd, input logic we);
    set_in(k, pc, cmp, add, pt, ptg, rob, pd, we);
    wait_accept("push_timeout");
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cdb_valid"}, cdb_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_cdb_target"}, cdb_target, 32'd0);
    check({tag, "_cdb_mispredict"}, cdb_mispredict, 1'b0);
    check({tag, "_cdb_data"}, cdb_data, 32'd0);
`ifdef BR_RESOLVE_PERF_EN
    check({tag, "_perf_resolved"}, perf_resolved, 32'd0);
    check({tag, "_perf_mispredict"}, perf_mispredict, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cdb_ready = 1'b0;
    rand_done = 1'b0;
    set_in(BR_KIND_BR, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 6'd0, 1'b0);
    in_valid  = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    check("post_reset_cdb_valid", cdb_valid, 1'b0);

    // Directed resolution cases, each pushed into an empty FIFO.
    cdb_ready = 1'b1;
    push(BR_KIND_BR, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0, 5'd1, 6'd2, 1'b1);
    check("br_taken_valid", cdb_valid, 1'b1);
    check("br_taken_mis", cdb_mispredict, 1'b1);
    check("br_taken_target", cdb_target, 32'h140);
    check("br_taken_rd_we", cdb_rd_we, 1'b0);
    idle(2);
    check("drained_valid", cdb_valid, 1'b0);

    push(BR_KIND_JALR, 32'h200, 1'b0, 32'h80, 1'b1, 32'h80, 5'd2, 6'd3, 1'b1);
    check("jalr_mis", cdb_mispredict, 1'b0);
    check("jalr_target", cdb_target, 32'h80);
    check("jalr_data", cdb_data, 32'h204);
    idle(2);

    push(BR_KIND_BR, 32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b0, 32'h0, 5'd3, 6'd4, 1'b1);
    check("br_wrap_target", cdb_target, 32'h0);
    check("br_wrap_mis", cdb_mispredict, 1'b0);
    idle(2);

    push(BR_KIND_JAL, 32'h1000, 1'b0, 32'h2000, 1'b1, 32'h3000, 5'd4, 6'd5, 1'b1);
    check("jal_target_mis", cdb_mispredict, 1'b1);
    check("jal_data", cdb_data, 32'h1004);
    idle(2);

    // Back-pressure: two held, third blocked, then drain in order.
    cdb_ready = 1'b0;
    push(BR_KIND_BR, 32'h400, 1'b1, 32'h480, 1'b1, 32'h480, 5'd10, 6'd1, 1'b0);
    push(BR_KIND_JAL, 32'h500, 1'b0, 32'h600, 1'b0, 32'h0, 5'd11, 6'd2, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    set_in(BR_KIND_JALR, 32'h700, 1'b0, 32'h10, 1'b1, 32'h14, 5'd12, 6'd3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("blocked_in_ready", in_ready, 1'b0);
      check("held_head_rob", cdb_rob_idx, 5'd10);
    end
    @(posedge clk);
    #1 cdb_ready = 1'b1;
    wait_accept("third_push_timeout");
    idle(4);
    check("drain_valid", cdb_valid, 1'b0);
    check("drain_sb_empty", sb.size(), 0);

    // Flush with two held and a push offered in the same cycle.
    cdb_ready = 1'b0;
    push(BR_KIND_BR, 32'h800, 1'b0, 32'h900, 1'b0, 32'h0, 5'd20, 6'd1, 1'b0);
    push(BR_KIND_BR, 32'h804, 1'b1, 32'h900, 1'b1, 32'h900, 5'd21, 6'd1, 1'b0);
    set_in(BR_KIND_JAL, 32'h808, 1'b0, 32'hA00, 1'b1, 32'hA00, 5'd22, 6'd2, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_cdb_valid", cdb_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    cdb_ready = 1'b1;
    idle(3);
    check("post_flush_valid", cdb_valid, 1'b0);

    // Asynchronous reset in the middle of a cycle with two entries held.
    cdb_ready = 1'b0;
    push(BR_KIND_JAL, 32'hC00, 1'b0, 32'hD00, 1'b0, 32'h0, 5'd25, 6'd7, 1'b1);
    push(BR_KIND_JAL, 32'hC04, 1'b0, 32'hD04, 1'b0, 32'h0, 5'd26, 6'd8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cdb_ready = 1'b1;
    idle(3);
    check("post_reset_release_valid", cdb_valid, 1'b0);

    // Random traffic with random CDB back-pressure.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 cdb_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  kk;
      logic [31:0] add;
      kk  = 2'($urandom_range(0, 2));
      add = $urandom;
      push(br_kind_t'(kk), $urandom, 1'($urandom), add, 1'($urandom),
           ($urandom_range(0, 1) != 0) ? add : $urandom, 5'(i), 6'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_done = 1'b1;
    @(posedge clk);
    #2 cdb_ready = 1'b1;
    idle(6);
    check("final_sb_empty", sb.size(), 0);
    check("final_cdb_valid", cdb_valid, 1'b0);
`ifdef BR_RESOLVE_PERF_EN
    check("perf_resolved", perf_resolved, exp_resolved);
    check("perf_mispredict", perf_mispredict, exp_mispredict);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
